// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
    localparam int unsigned MAX_DATA_BYTES = 8;

    // Frame checksum: address XOR every payload byte (byte 0 = LSB of data).
    function automatic logic [7:0] cksum_xor(input logic [7:0]  addr,
                                             input logic [63:0] data,
                                             input int unsigned nbytes);
        logic [7:0] acc;
        acc = addr;
        for (int unsigned i = 0; i < MAX_DATA_BYTES; i++) begin
            if (i < nbytes) acc = acc ^ data[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: expire_c fires on the edge the idle count would reach TIMEOUT_CLKS-1.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc  = cnt + CNT_W'(1);
    // A coincident strobe always beats expiry.
    assign expire_c = enable && !clear && (cnt_inc == CNT_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || !enable || expire_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles SYNC/ADDR/DATA/CKSUM frames from UART byte strobes into register writes.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_BYTES   = 4,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic                    osc_clk,
    input  logic                    i_Rst,
    input  logic                    i_Rx_DV,
    input  logic [7:0]              i_Rx_Byte,
    input  logic                    i_Wr_Ready,
    output logic                    o_Wr_En,
    output logic [7:0]              o_Wr_Addr,
    output logic [DATA_BYTES*8-1:0] o_Wr_Data,
    output logic                    o_Busy,
    output logic                    o_Err_Cksum,
    output logic                    o_Err_Timeout,
    output logic                    o_Err_Overrun,
    output logic [7:0]              o_Frame_Cnt
);

    localparam int unsigned DATA_W = DATA_BYTES * 8;
    localparam int unsigned IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    state_t              state, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          ck_q, ck_d;
    logic [7:0]          wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                err_ck_d, err_to_d, err_ov_d;
    logic [7:0]          frame_cnt_d;
    logic                timer_en;
    logic                expire_c;

    assign timer_en = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CKSUM);

    cmd_timeout_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk      (osc_clk),
        .rst      (i_Rst),
        .enable   (timer_en),
        .clear    (i_Rx_DV),
        .expire_c (expire_c)
    );

    always_ff @(posedge osc_clk) begin
        if (i_Rst) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            idx_q         <= '0;
            ck_q          <= '0;
            o_Wr_En       <= 1'b0;
            o_Wr_Addr     <= '0;
            o_Wr_Data     <= '0;
            o_Busy        <= 1'b0;
            o_Err_Cksum   <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Err_Overrun <= 1'b0;
            o_Frame_Cnt   <= '0;
        end else begin
            state         <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            idx_q         <= idx_d;
            ck_q          <= ck_d;
            o_Wr_En       <= (state_d == ST_WRITE);
            o_Wr_Addr     <= wr_addr_d;
            o_Wr_Data     <= wr_data_d;
            o_Busy        <= (state_d != ST_IDLE);
            o_Err_Cksum   <= err_ck_d;
            o_Err_Timeout <= err_to_d;
            o_Err_Overrun <= err_ov_d;
            o_Frame_Cnt   <= frame_cnt_d;
        end
    end

    // Next-state and datapath; write outputs update only on a good checksum.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        data_d      = data_q;
        idx_d       = idx_q;
        ck_d        = ck_q;
        wr_addr_d   = o_Wr_Addr;
        wr_data_d   = o_Wr_Data;
        err_ck_d    = 1'b0;
        err_to_d    = 1'b0;
        err_ov_d    = 1'b0;
        frame_cnt_d = o_Frame_Cnt;

        case (state)
            ST_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    ck_d    = i_Rx_Byte;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else if (expire_c) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    data_d = (data_q << 8) | DATA_W'(i_Rx_Byte);
                    ck_d   = ck_q ^ i_Rx_Byte;
                    if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
                        state_d = ST_CKSUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (expire_c) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_CKSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == ck_q) begin
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                        state_d   = ST_WRITE;
                    end else begin
                        err_ck_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (expire_c) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Bytes arriving mid-write are dropped, including SYNC.
                if (i_Rx_DV) err_ov_d = 1'b1;
                if (o_Wr_En && i_Wr_Ready) begin
                    frame_cnt_d = o_Frame_Cnt + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected writes/errors, a monitor pops and compares.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int unsigned DB   = 4;
    localparam int unsigned TO   = 100;
    localparam int          E_CK = 1;
    localparam int          E_TO = 2;
    localparam int          E_OV = 3;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  cnt;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [7:0]  rx_byte;
    logic        ready;
    logic        o_Wr_En;
    logic [7:0]  o_Wr_Addr;
    logic [31:0] o_Wr_Data;
    logic        o_Busy;
    logic        o_Err_Cksum;
    logic        o_Err_Timeout;
    logic        o_Err_Overrun;
    logic [7:0]  o_Frame_Cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    wr_t         exp_wr[$];
    int          exp_err[$];
    int unsigned exp_frames = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .DATA_BYTES  (DB),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .osc_clk      (clk),
        .i_Rst        (rst),
        .i_Rx_DV      (dv),
        .i_Rx_Byte    (rx_byte),
        .i_Wr_Ready   (ready),
        .o_Wr_En      (o_Wr_En),
        .o_Wr_Addr    (o_Wr_Addr),
        .o_Wr_Data    (o_Wr_Data),
        .o_Busy       (o_Busy),
        .o_Err_Cksum  (o_Err_Cksum),
        .o_Err_Timeout(o_Err_Timeout),
        .o_Err_Overrun(o_Err_Overrun),
        .o_Frame_Cnt  (o_Frame_Cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: writes on handshake, error pulses, and addr/data stability while stalled.
    logic        prev_en = 1'b0;
    logic        prev_hs = 1'b0;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (o_Wr_En && ready) begin
                if (exp_wr.size() == 0) begin
                    check("write_expected", 64'(exp_wr.size()), 64'd1);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_payload", 64'({o_Wr_Addr, o_Wr_Data, o_Frame_Cnt}), 64'(e));
                end
            end
            if (o_Err_Cksum || o_Err_Timeout || o_Err_Overrun) begin
                int kind;
                kind = o_Err_Cksum ? E_CK : (o_Err_Timeout ? E_TO : E_OV);
                check("err_onehot", 64'($countones({o_Err_Cksum, o_Err_Timeout, o_Err_Overrun})), 64'd1);
                if (exp_err.size() == 0) begin
                    check("err_expected", 64'(kind), 64'd0);
                end else begin
                    check("err_kind", 64'(kind), 64'(exp_err.pop_front()));
                end
            end
            if (prev_en && !prev_hs && o_Wr_En) begin
                check("wr_stable", 64'({o_Wr_Addr, o_Wr_Data}), 64'({prev_addr, prev_data}));
            end
        end
        prev_en   = o_Wr_En;
        prev_hs   = o_Wr_En && ready;
        prev_addr = o_Wr_Addr;
        prev_data = o_Wr_Data;
    end

    // All stimulus tasks start and end 1ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        dv      = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        dv      = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_hdr_data(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'hA5);
        send_byte(a);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        exp_wr.push_back('{addr: a, data: d, cnt: 8'(exp_frames)});
        exp_frames++;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
        push_wr(a, d);
        send_hdr_data(a, d);
        send_byte(cksum_xor(a, 64'(d), DB));
        idle(2);
    endtask

    initial begin
        int seen;
        int hi;
        rst = 1'b1; dv = 1'b0; rx_byte = 8'h00; ready = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset_outputs", 64'({o_Wr_En, o_Busy, o_Err_Cksum, o_Err_Timeout, o_Err_Overrun,
                                     o_Wr_Addr, o_Wr_Data, o_Frame_Cnt}), 64'd0);

        // Good frame, ready already high: single-cycle write.
        push_wr(8'h10, 32'h12345678);
        send_hdr_data(8'h10, 32'h12345678);
        send_byte(8'h18);
        check("t1_wr_en_next", 64'(o_Wr_En), 64'd1);
        check("t1_addr_data", 64'({o_Wr_Addr, o_Wr_Data}), 64'h10_12345678);
        idle(1);
        check("t1_wr_en_drop", 64'(o_Wr_En), 64'd0);
        check("t1_frame_cnt", 64'(o_Frame_Cnt), 64'd1);
        idle(1);

        // Bad checksum.
        exp_err.push_back(E_CK);
        send_hdr_data(8'h10, 32'h12345678);
        send_byte(8'h19);
        check("t2_busy", 64'(o_Busy), 64'd0);
        check("t2_wr_en", 64'(o_Wr_En), 64'd0);
        idle(2);

        // Inter-byte timeout after the address byte.
        exp_err.push_back(E_TO);
        send_byte(8'hA5);
        send_byte(8'h10);
        seen = -1;
        for (int k = 1; k <= 150; k++) begin
            idle(1);
            if (o_Err_Timeout && seen < 0) seen = k;
        end
        check("t3_timeout_cycle", 64'(seen), 64'd99);
        check("t3_idle", 64'(o_Busy), 64'd0);
        send_frame(8'h42, 32'hCAFEF00D);
        check("t3_frame_cnt", 64'(o_Frame_Cnt), 64'd2);

        // Stalled write with an overrun byte.
        ready = 1'b0;
        push_wr(8'h07, 32'hDEADBEEF);
        send_hdr_data(8'h07, 32'hDEADBEEF);
        send_byte(cksum_xor(8'h07, 64'h0000_0000_DEAD_BEEF, DB));
        hi = 0;
        exp_err.push_back(E_OV);
        for (int i = 0; i < 20; i++) begin
            if (o_Wr_En) hi++;
            dv      = (i == 7);
            rx_byte = (i == 7) ? 8'h55 : 8'h00;
            idle(1);
        end
        dv = 1'b0;
        check("t4_wr_en_held", 64'(hi), 64'd20);
        ready = 1'b1;
        idle(1);
        check("t4_wr_en_drop", 64'(o_Wr_En), 64'd0);
        check("t4_frame_cnt", 64'(o_Frame_Cnt), 64'd3);
        idle(1);

        // Junk before SYNC is ignored.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h33, 32'h01020304);
        check("t5_frame_cnt", 64'(o_Frame_Cnt), 64'd4);

        // Strobe on the expiry cycle wins over the timeout.
        push_wr(8'h20, 32'h11223344);
        send_byte(8'hA5);
        send_byte(8'h20);
        idle(98);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h64);
        idle(2);
        check("t5_coincident_cnt", 64'(o_Frame_Cnt), 64'd5);

        // Reset after the third data byte abandons the frame silently.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_frames = 0;
        check("t6_reset_outputs", 64'({o_Wr_En, o_Busy, o_Err_Cksum, o_Err_Timeout, o_Err_Overrun,
                                        o_Wr_Addr, o_Wr_Data, o_Frame_Cnt}), 64'd0);

        // 256 frames: counter wraps to zero.
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), {8'(i), 8'(~i), 8'(i * 3), 8'hC3});
            if (i == 254) check("t6_cnt_255", 64'(o_Frame_Cnt), 64'd255);
        end
        check("t6_cnt_wrap", 64'(o_Frame_Cnt), 64'd0);

        idle(3);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("err_queue_drained", 64'(exp_err.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer downstream of the UART receiver. It consumes the one-cycle byte strobes (o_Rx_DV / o_Rx_Byte) that the receiver delivers in the osc_clk domain and assembles framed commands: SYNC, ADDR, DATA_BYTES data bytes (MSB first), then an XOR checksum. Each valid frame becomes one register-write transaction, with a valid/ready handshake, toward the SDR configuration registers (NCO tuning word, gain, filter select). Malformed, stalled and overrun frames are rejected and flagged.

Parameters:
DATA_BYTES, 4, payload bytes per frame (1..8); write data width is DATA_BYTES*8.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 1000000, maximum osc_clk cycles allowed between consecutive bytes inside a frame (at least 2).

Ports:
osc_clk  in  1  system clock; all logic on its rising edge.
i_Rst  in  1  synchronous, active-high reset.
i_Rx_DV  in  1  byte strobe, one cycle wide, from the UART receiver.
i_Rx_Byte  in  8  received byte; valid only when i_Rx_DV=1.
i_Wr_Ready  in  1  register bank accepts the write.
o_Wr_En  out  1  write valid; held until handshake.
o_Wr_Addr  out  8  register address.
o_Wr_Data  out  DATA_BYTES*8  register data.
o_Busy  out  1  high whenever state is not IDLE.
o_Err_Cksum  out  1  one-cycle pulse on checksum mismatch.
o_Err_Timeout  out  1  one-cycle pulse on inter-byte timeout.
o_Err_Overrun  out  1  one-cycle pulse when a byte arrives during WRITE.
o_Frame_Cnt  out  8  count of completed writes; wraps 255 to 0.

Behaviour:
- Reset (i_Rst=1 at a clock edge): state=IDLE. All outputs 0. Byte index, checksum accumulator and timeout counter cleared. Reset mid-frame or mid-WRITE abandons the transaction with no error pulse.
- IDLE: on i_Rx_DV with byte==SYNC_BYTE, go to ADDR. Other bytes are ignored silently.
- ADDR: on i_Rx_DV, latch the byte into the address register, set cksum=byte, set index=0, go to DATA.
- DATA: on i_Rx_DV, shift data left by 8 and insert the byte into the LSBs; cksum ^= byte. When index reaches DATA_BYTES-1, go to CKSUM; otherwise increment index.
- CKSUM: on i_Rx_DV:
  - byte==cksum: go to WRITE and assert o_Wr_En next cycle, with o_Wr_Addr and o_Wr_Data stable.
  - otherwise: pulse o_Err_Cksum and go to IDLE. o_Wr_Addr and o_Wr_Data keep their previous values.
- WRITE: o_Wr_En=1 until a cycle where o_Wr_En and i_Wr_Ready are both 1. On that edge: o_Wr_En drops to 0, o_Frame_Cnt increments, state goes to IDLE.
  - Addr and data do not change while o_Wr_En=1.
  - If i_Wr_Ready is already high, the write completes in 1 cycle.
- Latency: last (checksum) strobe at cycle N gives o_Wr_En=1 at N+1. Earliest return to IDLE is N+2.
- Overrun: i_Rx_DV while in WRITE drops the byte and pulses o_Err_Overrun; the write continues. A SYNC byte received during WRITE is also dropped and does not start a frame.
- Timeout: the counter runs in ADDR, DATA and CKSUM, and clears on every i_Rx_DV and on entry to ADDR. When the counter reaches TIMEOUT_CLKS-1 with no strobe, pulse o_Err_Timeout and go to IDLE. Timeout is not active in IDLE or WRITE.
- i_Rx_DV in the same cycle as timeout expiry: the byte wins. It is processed normally, no timeout pulse is generated, and the counter clears.
- Counter width: $clog2(TIMEOUT_CLKS). Saturation is unreachable.
- Error pulses are mutually exclusive by construction; at most one fires per cycle.

Decomposition:
- Package uart_cmd_pkg holds:
  - state encoding (IDLE, ADDR, DATA, CKSUM, WRITE; 3-bit),
  - SYNC_BYTE default,
  - a checksum-XOR function for use by the bench model.
- One sub-module, cmd_timeout_timer. Inputs: clk, rst, enable, clear. Output: expire pulse. Parameter: TIMEOUT_CLKS.

Test Plan:
1. Bytes A5,10,12,34,56,78, cksum 10^12^34^56^78=0x18, with i_Wr_Ready=1 -> one o_Wr_En cycle, Addr=0x10, Data=0x12345678, o_Frame_Cnt=1, no error pulses.
2. Same frame with cksum 0x19 -> o_Err_Cksum pulse, o_Wr_En never high, o_Busy=0 one cycle after the bad byte.
3. TIMEOUT_CLKS=100; send A5,10 then idle 150 cycles -> o_Err_Timeout pulse exactly 99 cycles after the 0x10 strobe, state IDLE. A following valid frame is accepted.
4. Valid frame with i_Wr_Ready=0 for 20 cycles; inject byte 0x55 during the stall -> o_Err_Overrun pulse, o_Wr_En held 20 cycles with stable addr/data, then completes on i_Wr_Ready=1.
5. Bytes 00,FF,A5 then a valid frame -> junk ignored, single write performed. Strobe coincident with timeout expiry (cycle 99) -> byte processed, no timeout pulse.
6. Assert i_Rst for one cycle after the third data byte -> all outputs 0 next cycle. 256 consecutive valid frames -> o_Frame_Cnt wraps to 0.
